// File: rtl/disp_pkg.sv
// Shared helpers for the display scan multiplexer: index widths and
// pin-polarity patterns. Vectors are returned at MAX_W bits and sized
// down by the caller, so NUM_DIGITS and SEG_W must not exceed MAX_W.
package disp_pkg;

    localparam int MAX_W          = 32;
    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_DIG_W      = $clog2(DEF_NUM_DIGITS);

    // Width of an index counter for n states (at least one bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Anode word with only digit idx driven on.
    function automatic logic [MAX_W-1:0] an_on(input int idx, input bit active_low);
        logic [MAX_W-1:0] v;
        v = {{(MAX_W-1){1'b0}}, 1'b1} << idx;
        return active_low ? ~v : v;
    endfunction

    // Anode word with every digit off.
    function automatic logic [MAX_W-1:0] an_off(input bit active_low);
        return active_low ? {MAX_W{1'b1}} : {MAX_W{1'b0}};
    endfunction

    // Segment word with every segment dark.
    function automatic logic [MAX_W-1:0] seg_blank(input bit active_low);
        return active_low ? {MAX_W{1'b1}} : {MAX_W{1'b0}};
    endfunction

endpackage

// File: rtl/disp_pwm_timer.sv
// Nested scan counters: prescaler -> PWM step -> digit.
// Exposes next-state values so the owner can register outputs that move
// on the same edge as the counters. When i_en is low the counters are
// held at zero; the first enabled edge keeps them at zero so the scan
// starts cleanly at digit 0, step 0, pre 0.
module disp_pwm_timer
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4,
    parameter int STEP_DIV   = 1563
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_en,
    output logic [BRIGHT_W-1:0]           o_step_nxt,
    output logic [idx_w(NUM_DIGITS)-1:0]  o_digit_nxt,
    output logic                          o_frame_wrap,
    output logic                          o_frame_start_nxt
);

    localparam int PRE_W = idx_w(STEP_DIV);
    localparam int DIG_W = idx_w(NUM_DIGITS);

    logic [PRE_W-1:0]    r_pre;
    logic [BRIGHT_W-1:0] r_step;
    logic [DIG_W-1:0]    r_digit;
    logic                r_run;

    logic [PRE_W-1:0]    w_pre_nxt;
    logic [BRIGHT_W-1:0] w_step_nxt;
    logic [DIG_W-1:0]    w_digit_nxt;
    logic                w_pre_wrap;
    logic                w_step_wrap;
    logic                w_dig_wrap;
    logic                w_adv;

    // Next-state counters; the step counter wraps naturally at 2^BRIGHT_W.
    always_comb begin
        w_pre_wrap  = (r_pre == PRE_W'(STEP_DIV - 1));
        w_step_wrap = w_pre_wrap && (r_step == {BRIGHT_W{1'b1}});
        w_dig_wrap  = w_step_wrap && (r_digit == DIG_W'(NUM_DIGITS - 1));
        w_adv       = i_en && r_run;
        w_pre_nxt   = '0;
        w_step_nxt  = '0;
        w_digit_nxt = '0;
        if (w_adv) begin
            w_pre_nxt   = w_pre_wrap ? '0 : r_pre + 1'b1;
            w_step_nxt  = w_pre_wrap ? r_step + 1'b1 : r_step;
            w_digit_nxt = r_digit;
            if (w_step_wrap) begin
                w_digit_nxt = w_dig_wrap ? '0 : r_digit + 1'b1;
            end
        end
    end

    assign o_step_nxt        = w_step_nxt;
    assign o_digit_nxt       = w_digit_nxt;
    assign o_frame_wrap      = w_adv && w_dig_wrap;
    assign o_frame_start_nxt = i_en && (!r_run || w_dig_wrap);

    // Counter and run-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_step  <= '0;
            r_digit <= '0;
            r_run   <= 1'b0;
        end else begin
            r_pre   <= w_pre_nxt;
            r_step  <= w_step_nxt;
            r_digit <= w_digit_nxt;
            r_run   <= i_en;
        end
    end

endmodule

// File: rtl/disp_scan_mux.sv
// Seven-segment scan multiplexer with per-digit blanking, PWM brightness
// and a double-buffered shadow that only updates on frame boundaries
// (or immediately while the scan is disabled). All pin outputs are
// registered from next-state values, so anode and segment change together.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SEG_W          = 8,
    parameter int BRIGHT_W       = 4,
    parameter int STEP_DIV       = 1563,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NUM_DIGITS*SEG_W-1:0]   seg_data,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [BRIGHT_W-1:0]           brightness,
    input  logic                          load,
    output logic                          busy,
    output logic                          frame_start,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [SEG_W-1:0]              sseg,
    output logic [$clog2(NUM_DIGITS)-1:0] cur_digit
);

    localparam int DIG_W = $clog2(NUM_DIGITS);
    localparam logic [SEG_W-1:0]      SEG_BLANK = SEG_W'(seg_blank(SEG_ACTIVE_LOW != 0));
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = NUM_DIGITS'(an_off(AN_ACTIVE_LOW != 0));

    logic [BRIGHT_W-1:0]         w_step_nxt;
    logic [DIG_W-1:0]            w_digit_nxt;
    logic                        w_frame_wrap;
    logic                        w_frame_start_nxt;

    logic [NUM_DIGITS*SEG_W-1:0] r_sh_seg;
    logic [NUM_DIGITS-1:0]       r_sh_en;
    logic [BRIGHT_W-1:0]         r_sh_bright;
    logic                        r_busy;
    logic                        r_frame_start;
    logic [NUM_DIGITS-1:0]       r_an;
    logic [SEG_W-1:0]            r_sseg;
    logic [DIG_W-1:0]            r_cur_digit;

    logic                        w_capture;
    logic                        w_busy_nxt;
    logic [NUM_DIGITS*SEG_W-1:0] w_sh_seg_nxt;
    logic [NUM_DIGITS-1:0]       w_sh_en_nxt;
    logic [BRIGHT_W-1:0]         w_sh_bright_nxt;
    logic [SEG_W-1:0]            w_pat [NUM_DIGITS];
    logic                        w_lit;
    logic [NUM_DIGITS-1:0]       w_an_nxt;
    logic [SEG_W-1:0]            w_sseg_nxt;

    disp_pwm_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .BRIGHT_W   (BRIGHT_W),
        .STEP_DIV   (STEP_DIV)
    ) u_timer (
        .clk               (clk),
        .reset             (reset),
        .i_en              (en),
        .o_step_nxt        (w_step_nxt),
        .o_digit_nxt       (w_digit_nxt),
        .o_frame_wrap      (w_frame_wrap),
        .o_frame_start_nxt (w_frame_start_nxt)
    );

    // Shadow update: a pending or same-cycle load lands at a frame wrap,
    // or on the next edge whenever nothing is being displayed.
    always_comb begin
        w_capture       = (r_busy || load) && (w_frame_wrap || !en);
        w_busy_nxt      = r_busy;
        if (w_capture) begin
            w_busy_nxt = 1'b0;
        end else if (load) begin
            w_busy_nxt = 1'b1;
        end
        w_sh_seg_nxt    = w_capture ? seg_data   : r_sh_seg;
        w_sh_en_nxt     = w_capture ? digit_en   : r_sh_en;
        w_sh_bright_nxt = w_capture ? brightness : r_sh_bright;
    end

    // Pin values for the next cycle from next-state counters and shadow.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_pat[i] = w_sh_seg_nxt[i*SEG_W +: SEG_W];
        end
        w_lit      = en && w_sh_en_nxt[w_digit_nxt] && (w_step_nxt <= w_sh_bright_nxt);
        w_an_nxt   = AN_OFF;
        w_sseg_nxt = SEG_BLANK;
        if (w_lit) begin
            w_an_nxt   = NUM_DIGITS'(an_on(int'(w_digit_nxt), AN_ACTIVE_LOW != 0));
            w_sseg_nxt = w_pat[w_digit_nxt];
        end
    end

    // Shadow, busy flag and registered pin outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_seg      <= {NUM_DIGITS{SEG_BLANK}};
            r_sh_en       <= '0;
            r_sh_bright   <= '1;
            r_busy        <= 1'b0;
            r_frame_start <= 1'b0;
            r_an          <= AN_OFF;
            r_sseg        <= SEG_BLANK;
            r_cur_digit   <= '0;
        end else begin
            r_sh_seg      <= w_sh_seg_nxt;
            r_sh_en       <= w_sh_en_nxt;
            r_sh_bright   <= w_sh_bright_nxt;
            r_busy        <= w_busy_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_an          <= w_an_nxt;
            r_sseg        <= w_sseg_nxt;
            r_cur_digit   <= w_digit_nxt;
        end
    end

    assign busy        = r_busy;
    assign frame_start = r_frame_start;
    assign an          = r_an;
    assign sseg        = r_sseg;
    assign cur_digit   = r_cur_digit;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux at 4 digits, 2-bit brightness,
// 3-cycle prescaler: 12-cycle digit slot, 48-cycle frame.
module tb_disp_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] seg_data;
    logic [3:0]  digit_en;
    logic [1:0]  brightness;
    logic        load;
    logic        busy;
    logic        frame_start;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [1:0]  cur_digit;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0]      seg;
        logic [3:0]       den;
        logic [1:0]       bri;
        logic [3:0][3:0]  lit;      // lit cycles per 12-cycle slot, per digit
        logic [3:0][3:0]  an_lit;   // anode word when digit is lit
        logic [3:0][7:0]  exp_seg;  // segment word when digit is lit
    } vec_t;

    vec_t vecs [4];

    disp_scan_mux #(
        .NUM_DIGITS     (4),
        .SEG_W          (8),
        .BRIGHT_W       (2),
        .STEP_DIV       (3),
        .AN_ACTIVE_LOW  (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .seg_data    (seg_data),
        .digit_en    (digit_en),
        .brightness  (brightness),
        .load        (load),
        .busy        (busy),
        .frame_start (frame_start),
        .an          (an),
        .sseg        (sseg),
        .cur_digit   (cur_digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_fs();
        int c;
        c = 0;
        while (frame_start !== 1'b1 && c < 100) begin
            tick();
            c++;
        end
        chk("frame_start_timeout", 32'(frame_start), 32'd1);
    endtask

    function automatic vec_t mk(input logic [31:0] seg, input logic [3:0] den,
                                input logic [1:0] bri, input logic [15:0] lit,
                                input logic [31:0] exp_seg);
        vec_t v;
        v.seg     = seg;
        v.den     = den;
        v.bri     = bri;
        v.lit     = lit;
        v.an_lit  = 16'b0111_1011_1101_1110;
        v.exp_seg = exp_seg;
        return v;
    endfunction

    // One whole frame, starting on the frame_start cycle.
    task automatic run_frame(input vec_t v, input bit poke_seg);
        int d;
        int off;
        bit lit;
        for (int p = 0; p < 48; p++) begin
            d   = p / 12;
            off = p % 12;
            lit = off < int'(v.lit[d]);
            chk($sformatf("an p%0d", p), 32'(an), lit ? 32'(v.an_lit[d]) : 32'hF);
            chk($sformatf("sseg p%0d", p), 32'(sseg), lit ? 32'(v.exp_seg[d]) : 32'hFF);
            chk($sformatf("cur p%0d", p), 32'(cur_digit), 32'(d));
            chk($sformatf("fs p%0d", p), 32'(frame_start), 32'(p == 0));
            chk($sformatf("busy p%0d", p), 32'(busy), 32'd0);
            if (poke_seg && p == 20) seg_data = 32'hDEADBEEF;
            tick();
        end
    endtask

    task automatic apply_vec(input vec_t v);
        seg_data   = v.seg;
        digit_en   = v.den;
        brightness = v.bri;
        load       = 1'b1;
        tick();
        load       = 1'b0;
        chk("busy_after_load", 32'(busy), 32'd1);
        wait_fs();
        chk("busy_at_capture", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = mk(32'h039F250D, 4'hF, 2'd3, {4'd12, 4'd12, 4'd12, 4'd12}, 32'h039F250D);
        vecs[1] = mk(32'h039F250D, 4'hF, 2'd1, {4'd6,  4'd6,  4'd6,  4'd6 }, 32'h039F250D);
        vecs[2] = mk(32'h039F250D, 4'hA, 2'd3, {4'd12, 4'd0,  4'd12, 4'd0 }, 32'h039F250D);
        vecs[3] = mk(32'h11224488, 4'h6, 2'd0, {4'd0,  4'd3,  4'd3,  4'd0 }, 32'h11224488);

        // Reset state
        reset = 1'b1; en = 1'b0; load = 1'b0;
        seg_data = '0; digit_en = '0; brightness = '0;
        #12;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_sseg", 32'(sseg), 32'hFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_cur", 32'(cur_digit), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        en    = 1'b1;
        tick();

        // Enabled with no load: dark, frame_start every 48 cycles
        for (int k = 0; k < 100; k++) begin
            chk($sformatf("dark_an k%0d", k), 32'(an), 32'hF);
            chk($sformatf("dark_sseg k%0d", k), 32'(sseg), 32'hFF);
            chk($sformatf("dark_busy k%0d", k), 32'(busy), 32'd0);
            chk($sformatf("dark_fs k%0d", k), 32'(frame_start), 32'(k % 48 == 0));
            tick();
        end

        // Table: load each vector, then check a full frame
        for (int i = 0; i < 4; i++) begin
            apply_vec(vecs[i]);
            run_frame(vecs[i], i == 2);
        end

        // Load exactly in the boundary cycle: captured, busy never set
        ticks(47);
        chk("bnd_busy_before", 32'(busy), 32'd0);
        chk("bnd_cur_before", 32'(cur_digit), 32'd3);
        seg_data = 32'h039F250D; digit_en = 4'hF; brightness = 2'd3; load = 1'b1;
        tick();
        load = 1'b0;
        chk("bnd_busy", 32'(busy), 32'd0);
        chk("bnd_fs", 32'(frame_start), 32'd1);
        chk("bnd_an", 32'(an), 32'hE);
        chk("bnd_sseg", 32'(sseg), 32'h0D);
        tick();
        chk("bnd_busy_after", 32'(busy), 32'd0);

        // Two loads in one frame: one capture, data sampled at capture
        ticks(4);
        seg_data = 32'hAAAAAAAA; load = 1'b1;
        tick();
        load = 1'b0;
        chk("dbl_busy1", 32'(busy), 32'd1);
        chk("dbl_an_hold", 32'(an), 32'hE);
        chk("dbl_sseg_hold", 32'(sseg), 32'h0D);
        ticks(4);
        seg_data = 32'h81422418; load = 1'b1;
        tick();
        load = 1'b0;
        chk("dbl_busy2", 32'(busy), 32'd1);
        wait_fs();
        chk("dbl_busy_clr", 32'(busy), 32'd0);
        chk("dbl_an", 32'(an), 32'hE);
        chk("dbl_sseg", 32'(sseg), 32'h18);
        tick();
        chk("dbl_busy_stay", 32'(busy), 32'd0);

        // en dropped in digit 2, load while disabled, en raised again
        ticks(23);
        chk("en_cur2", 32'(cur_digit), 32'd2);
        chk("en_an2", 32'(an), 32'hB);
        chk("en_sseg2", 32'(sseg), 32'h42);
        en = 1'b0;
        tick();
        chk("en_off_an", 32'(an), 32'hF);
        chk("en_off_sseg", 32'(sseg), 32'hFF);
        chk("en_off_cur", 32'(cur_digit), 32'd0);
        chk("en_off_fs", 32'(frame_start), 32'd0);
        seg_data = 32'h0D259F03; digit_en = 4'hF; brightness = 2'd3; load = 1'b1;
        tick();
        load = 1'b0;
        chk("en_off_load_busy", 32'(busy), 32'd0);
        chk("en_off_load_an", 32'(an), 32'hF);
        en = 1'b1;
        tick();
        chk("en_on_fs", 32'(frame_start), 32'd1);
        chk("en_on_cur", 32'(cur_digit), 32'd0);
        chk("en_on_an", 32'(an), 32'hE);
        chk("en_on_sseg", 32'(sseg), 32'h03);
        tick();
        chk("en_on_fs_pulse", 32'(frame_start), 32'd0);

        // Asynchronous reset mid-slot, then shadow is gone
        ticks(3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_sseg", 32'(sseg), 32'hFF);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cur", 32'(cur_digit), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_fs", 32'(frame_start), 32'd1);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("post_rst_an k%0d", k), 32'(an), 32'hF);
            chk($sformatf("post_rst_sseg k%0d", k), 32'(sseg), 32'hFF);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
